seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Time-multiplexes one shared, programmable Mealy pattern-detection engine across NUM_LANES serial bit streams.
- Each lane keeps its own saved context (bit history plus fill count).
- A round-robin arbiter grants one lane per cycle. The engine updates that lane's context and reports matches tagged with the lane ID.
- Sits between the serial front-end lanes and the event/interrupt logic. Replaces one hard-wired detector per lane.

Parameters:
- NUM_LANES, 4: number of serial requester lanes (2..16).
- PAT_LEN, 4: pattern length in bits (2..8).
- PATTERN_RST, 4'b0111: pattern loaded at reset (PAT_LEN bits).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  enable servicing of lanes
- cfg_we  in  1  load new pattern; one-cycle strobe
- cfg_pattern  in  PAT_LEN  new pattern; bit PAT_LEN-1 is the first-received bit
- in_valid  in  NUM_LANES  per-lane bit valid
- in_bit  in  NUM_LANES  per-lane serial bit
- in_ready  out  NUM_LANES  per-lane accept; one-hot or zero
- match_valid  out  1  match pulse, one cycle
- match_lane  out  $clog2(NUM_LANES)  lane that matched
- busy  out  1  context clear in progress
- Interface rule: reset rst, asynchronous, active-low; clock clk.

Behaviour:
- Reset values (rst=0):
  - state=IDLE, arbiter pointer=0, pattern=PATTERN_RST.
  - All lane contexts cleared (history=0, fill=0).
  - in_ready=0, match_valid=0, match_lane=0, busy=0.
- FSM states: IDLE, RUN, CLEAR.
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0. Lane contexts are retained.
  - Any state -> CLEAR when cfg_we=1. The pattern register loads cfg_pattern on the same edge.
  - CLEAR lasts exactly NUM_LANES cycles, clearing one lane context per cycle, lane 0 first.
  - On exit, CLEAR -> RUN if en=1, else IDLE.
  - cfg_we during CLEAR reloads the pattern and restarts the clear count from lane 0.
  - busy=1 exactly while in CLEAR.
- Arbitration (RUN only):
  - Grant = first lane with in_valid=1, searching from the pointer upward with wrap.
  - in_ready[grant]=1 combinationally in the same cycle. in_ready=0 in IDLE and CLEAR.
  - Transfer occurs on in_valid & in_ready. After a transfer, pointer <= grant+1 mod NUM_LANES.
  - If no lane is valid, the pointer holds.
  - A requester must not make in_valid depend on in_ready. in_valid/in_bit are held until transfer.
- Engine (Mealy):
  - Lane context = last PAT_LEN-1 received bits plus a saturating fill count (0..PAT_LEN-1).
  - Match condition: {history, in_bit} == pattern AND fill == PAT_LEN-1.
  - Overlapping matches are detected. For example, pattern 0101 with stream 0101010 gives 2 matches.
  - The context write-back occurs on the transfer edge.
- Output timing:
  - match_valid/match_lane are registered, one cycle after the transfer edge.
  - Maximum one match per cycle.
  - match_lane holds its last value when match_valid=0.
- Mid-operation events:
  - cfg_we arriving in the same cycle as a RUN transfer: the transfer is suppressed (in_ready forced 0). No match is produced from the old pattern.
  - A match already registered from the previous cycle still emits.
  - Asynchronous reset mid-CLEAR: all contexts clear immediately.

Optional Feature:
- Macro: SEQ_DET_SCHED_CNT_EN.
- When defined:
  - Adds ports cnt_sel (in, $clog2(NUM_LANES)) and cnt_data (out, 8).
  - Each lane has an 8-bit match counter that saturates at 255.
  - cnt_data = counter[cnt_sel], combinational read.
  - A lane's counter clears when CLEAR processes that lane, and on reset.
- When undefined: no counters and no ports; all other behaviour is identical.

Decomposition:
- Package seq_det_sched_pkg holds:
  - FSM state enum (IDLE, RUN, CLEAR).
  - Default PATTERN_RST constant.
  - Lane context struct (history, fill).
- One sub-module, seq_det_engine: purely combinational.
  - Inputs: context, bit, pattern.
  - Outputs: next context, match.
- The arbiter, FSM, context array and output register stay in the top level.

Test Plan:
- Reset pattern 0111; lane 0 only, stream 0,1,1,1,1: match_valid with match_lane=0 exactly once, one cycle after the 4th-bit transfer. No match on the 5th bit.
- All 4 lanes valid continuously: in_ready rotates 0,1,2,3,0. Each lane receives 0,1,1,1 interleaved. Four matches appear with match_lane 0,1,2,3 on consecutive cycles.
- Lane 2 valid only, pointer at 3: lane 2 is granted. The next grant search starts at lane 3.
- cfg_we with 0101 mid-stream: busy=1 for 4 cycles, in_ready=0 throughout, no match from the old pattern. Lane 1 stream 0101010 then yields 2 matches.
- en=0 after 2 bits into lane 0, then en=1 and send 1,1: the match fires, proving the context was retained.
- With SEQ_DET_SCHED_CNT_EN: 300 matches on lane 3 give cnt_data=255 with cnt_sel=3, and cfg_we returns it to 0.

Source files
------------

// File: rtl/seq_det_sched_pkg.sv
// Shared types and constants for the lane-multiplexed sequence detector.
// Imported by seq_det_engine and seq_det_sched.
package seq_det_sched_pkg;

  localparam int MAX_PAT = 8;

  localparam logic [3:0] PATTERN_RST_DEF = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // history sized for the longest pattern; unused upper bits stay zero
  typedef struct packed {
    logic [MAX_PAT-2:0] hist;
    logic [2:0]         fill;
  } lane_ctx_t;

endpackage

// File: rtl/seq_det_engine.sv
// Combinational Mealy step of the shared pattern engine.
// Shifts one bit into a lane context and flags a full-window match.
module seq_det_engine
  import seq_det_sched_pkg::*;
#(
  parameter int PAT_LEN = 4
) (
  input  lane_ctx_t          i_ctx,
  input  logic               i_bit,
  input  logic [PAT_LEN-1:0] i_pat,
  output lane_ctx_t          o_ctx,
  output logic               o_match
);

  localparam logic [MAX_PAT-1:0] PMASK =
    MAX_PAT'((9'd1 << PAT_LEN) - 9'd1);
  localparam logic [MAX_PAT-2:0] HMASK =
    (MAX_PAT-1)'((8'd1 << (PAT_LEN-1)) - 8'd1);
  localparam logic [2:0] LAST = 3'(PAT_LEN-1);

  logic [MAX_PAT-1:0] w_shift;
  logic               w_full;

  assign w_shift = {i_ctx.hist, i_bit};
  assign w_full  = (i_ctx.fill == LAST);

  assign o_match = w_full &&
    ((w_shift & PMASK) == MAX_PAT'(i_pat));

  assign o_ctx.hist = w_shift[MAX_PAT-2:0] & HMASK;
  assign o_ctx.fill = w_full ? LAST : i_ctx.fill + 3'd1;

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one pattern engine across serial lanes.
// Optional per-lane match counters: define SEQ_DET_SCHED_CNT_EN.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN_RST =
    PAT_LEN'(PATTERN_RST_DEF),
  localparam int LW = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic [PAT_LEN-1:0]   cfg_pattern,
  input  logic [NUM_LANES-1:0] in_valid,
  input  logic [NUM_LANES-1:0] in_bit,
  output logic [NUM_LANES-1:0] in_ready,
  output logic                 match_valid,
  output logic [LW-1:0]        match_lane,
  output logic                 busy
`ifdef SEQ_DET_SCHED_CNT_EN
  ,
  input  logic [LW-1:0]        cnt_sel,
  output logic [7:0]           cnt_data
`endif
);

  state_t             r_state;
  state_t             w_next;
  logic [LW-1:0]      r_ptr;
  logic [LW-1:0]      r_clr;
  logic [PAT_LEN-1:0] r_pat;
  lane_ctx_t          r_ctx [NUM_LANES];
  logic               r_mv;
  logic [LW-1:0]      r_ml;

  logic [LW-1:0]      w_gnt;
  logic               w_found;
  logic [LW:0]        w_k;
  logic               w_xfer;
  logic               w_clr_last;
  lane_ctx_t          w_nctx;
  logic               w_match;

  assign w_clr_last = (r_clr == LW'(NUM_LANES-1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next state; a pattern load always (re)starts a clear pass
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = en ? RUN : IDLE;
      RUN:     w_next = en ? RUN : IDLE;
      CLEAR:   if (w_clr_last) w_next = en ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
    if (cfg_we) w_next = CLEAR;
  end

  // outputs; a concurrent pattern load blocks the transfer
  always_comb begin
    in_ready = '0;
    busy     = (r_state == CLEAR);
    w_xfer   = (r_state == RUN) && !cfg_we && w_found;
    if (w_xfer) in_ready[w_gnt] = 1'b1;
  end

  // grant first valid lane at or above the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_k = {1'b0, r_ptr} + (LW+1)'(i);
      if (w_k >= (LW+1)'(NUM_LANES))
        w_k = w_k - (LW+1)'(NUM_LANES);
      if (!w_found && in_valid[w_k[LW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_k[LW-1:0];
      end
    end
  end

  seq_det_engine #(
    .PAT_LEN (PAT_LEN)
  ) u_engine (
    .i_ctx   (r_ctx[w_gnt]),
    .i_bit   (in_bit[w_gnt]),
    .i_pat   (r_pat),
    .o_ctx   (w_nctx),
    .o_match (w_match)
  );

  // round-robin pointer moves past the lane just served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      if (w_gnt == LW'(NUM_LANES-1)) r_ptr <= '0;
      else                           r_ptr <= w_gnt + 1'b1;
    end
  end

  // pattern register and clear-pass lane index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat <= PATTERN_RST;
      r_clr <= '0;
    end else if (cfg_we) begin
      r_pat <= cfg_pattern;
      r_clr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr <= r_clr + 1'b1;
    end
  end

  // per-lane saved contexts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_ctx[i] <= '0;
    end else if (r_state == CLEAR) begin
      r_ctx[r_clr] <= '0;
    end else if (w_xfer) begin
      r_ctx[w_gnt] <= w_nctx;
    end
  end

  // registered match pulse; lane tag holds between matches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mv <= 1'b0;
      r_ml <= '0;
    end else begin
      r_mv <= w_xfer && w_match;
      if (w_xfer && w_match) r_ml <= w_gnt;
    end
  end

  assign match_valid = r_mv;
  assign match_lane  = r_ml;

`ifdef SEQ_DET_SCHED_CNT_EN
  logic [7:0] r_cnt [NUM_LANES];

  // saturating per-lane match counters, wiped by the clear pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
    end else if (r_state == CLEAR) begin
      r_cnt[r_clr] <= '0;
    end else if (w_xfer && w_match && r_cnt[w_gnt] != 8'hff) begin
      r_cnt[w_gnt] <= r_cnt[w_gnt] + 8'd1;
    end
  end

  assign cnt_data = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed vector bench for seq_det_sched (4 lanes, 4-bit pattern).
// Counter checks compile in when SEQ_DET_SCHED_CNT_EN is defined.
module tb_seq_det_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] in_ready;
  logic       match_valid;
  logic [1:0] match_lane;
  logic       busy;
`ifdef SEQ_DET_SCHED_CNT_EN
  logic [1:0] cnt_sel;
  logic [7:0] cnt_data;
`endif

  int n_vec = 0;
  int n_bad = 0;

  seq_det_sched dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .match_valid (match_valid),
    .match_lane  (match_lane),
    .busy        (busy)
`ifdef SEQ_DET_SCHED_CNT_EN
    ,
    .cnt_sel     (cnt_sel),
    .cnt_data    (cnt_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       we;
    logic [3:0] pat;
    logic [3:0] v;
    logic [3:0] b;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] ml;
    logic       bz;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    logic e, logic w, logic [3:0] p, logic [3:0] v,
    logic [3:0] b, logic [3:0] r, logic mv,
    logic [1:0] ml, logic bz);
    vec_t t;
    t.en = e; t.we = w; t.pat = p; t.v = v; t.b = b;
    t.rdy = r; t.mv = mv; t.ml = ml; t.bz = bz;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic e, input logic w,
    input logic [3:0] p, input logic [3:0] v,
    input logic [3:0] b);
    en = e; cfg_we = w; cfg_pattern = p;
    in_valid = v; in_bit = b;
  endtask

  task automatic chk(input string nm, input logic [3:0] er,
    input logic emv, input logic [1:0] eml, input logic eb);
    #1;
    n_vec++;
    if (in_ready !== er || match_valid !== emv ||
        match_lane !== eml || busy !== eb) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b mv=%b ml=%0d busy=%b, want rdy=%b mv=%b ml=%0d busy=%b",
        nm, in_ready, match_valid, match_lane, busy,
        er, emv, eml, eb);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic row(input string nm, input logic e,
    input logic w, input logic [3:0] p, input logic [3:0] v,
    input logic [3:0] b, input logic [3:0] r, input logic mv,
    input logic [1:0] ml, input logic bz);
    drive(e, w, p, v, b);
    chk(nm, r, mv, ml, bz);
    tick();
  endtask

  initial begin
    // all lanes, rotation 0..3, each lane gets 0,1,1,1
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    add(1,0,0,4'b1111,4'b0000, 4'b0001,0,0,0);
    add(1,0,0,4'b1111,4'b0001, 4'b0010,0,0,0);
    add(1,0,0,4'b1111,4'b0011, 4'b0100,0,0,0);
    add(1,0,0,4'b1111,4'b0111, 4'b1000,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0001,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0010,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0100,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b1000,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0001,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0010,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0100,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b1000,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0001,0,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0010,1,0,0);
    add(1,0,0,4'b1111,4'b1111, 4'b0100,1,1,0);
    add(1,0,0,4'b1111,4'b1111, 4'b1000,1,2,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,1,3,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,3,0);
    // lane 0 alone: 0,1,1,1,1 -> one match
    add(1,0,0,4'b0001,4'b0000, 4'b0001,0,3,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,3,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,3,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,3,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,1,0,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    // lane 2 only, then search starts at lane 3
    add(1,0,0,4'b0100,4'b0000, 4'b0100,0,0,0);
    add(1,0,0,4'b0100,4'b0000, 4'b0100,0,0,0);
    add(1,0,0,4'b1100,4'b0000, 4'b1000,0,0,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    // lane 0: 0,1 then en=0 pause then 1,1 matches
    add(1,0,0,4'b0001,4'b0000, 4'b0001,0,0,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,0,0);
    add(0,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    add(0,0,0,4'b0001,4'b0001, 4'b0000,0,0,0);
    add(0,0,0,4'b0001,4'b0001, 4'b0000,0,0,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0000,0,0,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,0,0);
    add(1,0,0,4'b0001,4'b0001, 4'b0001,0,0,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,1,0,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    // lane 1: 0,1,1 then cfg_we 0101 kills the would-be match
    add(1,0,0,4'b0010,4'b0000, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0010,0,0,0);
    add(1,1,4'b0101,4'b0010,4'b0010, 4'b0000,0,0,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0000,0,0,1);
    add(1,0,0,4'b0010,4'b0010, 4'b0000,0,0,1);
    add(1,0,0,4'b0010,4'b0010, 4'b0000,0,0,1);
    add(1,0,0,4'b0010,4'b0010, 4'b0000,0,0,1);
    // lane 1: 0101010 under pattern 0101 -> two matches
    add(1,0,0,4'b0010,4'b0000, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0000, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0010,0,0,0);
    add(1,0,0,4'b0010,4'b0000, 4'b0010,1,1,0);
    add(1,0,0,4'b0010,4'b0010, 4'b0010,0,1,0);
    add(1,0,0,4'b0010,4'b0000, 4'b0010,1,1,0);
    add(1,0,0,4'b0000,4'b0000, 4'b0000,0,1,0);

    rst = 1'b1;
    drive(0, 0, 4'b0000, 4'b0000, 4'b0000);
`ifdef SEQ_DET_SCHED_CNT_EN
    cnt_sel = 2'd0;
`endif
    #2 rst = 1'b0;
    chk("reset", 4'b0000, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      row($sformatf("vec[%0d]", i), t.en, t.we, t.pat,
        t.v, t.b, t.rdy, t.mv, t.ml, t.bz);
    end

    // match registered just before cfg_we still emits
    row("pre_cfg_match", 1,0,0,4'b0010,4'b0010,
      4'b0010,0,1,0);
    row("cfg_emit", 1,1,4'b0111,4'b0000,4'b0000,
      4'b0000,1,1,0);
    row("clr0", 1,0,0,4'b0000,4'b0000, 4'b0000,0,1,1);
    row("clr_restart", 1,1,4'b0111,4'b0000,4'b0000,
      4'b0000,0,1,1);
    for (int i = 0; i < 4; i++)
      row($sformatf("clr_rs%0d", i), 1,0,0,4'b0000,4'b0000,
        4'b0000,0,1,1);
    row("clr_done", 1,0,0,4'b0000,4'b0000, 4'b0000,0,1,0);

    // load lane 3 with 0,1,1 then reset during CLEAR
    row("l3_b0", 1,0,0,4'b1000,4'b0000, 4'b1000,0,1,0);
    row("l3_b1", 1,0,0,4'b1000,4'b1000, 4'b1000,0,1,0);
    row("l3_b2", 1,0,0,4'b1000,4'b1000, 4'b1000,0,1,0);
    row("cfg1111", 1,1,4'b1111,4'b0000,4'b0000,
      4'b0000,0,1,0);
    row("clr_a", 1,0,0,4'b0000,4'b0000, 4'b0000,0,1,1);
    #2 rst = 1'b0;
    chk("async_rst", 4'b0000, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    row("rst_idle", 1,0,0,4'b0000,4'b0000, 4'b0000,0,0,0);
    row("pr_1", 1,0,0,4'b1000,4'b1000, 4'b1000,0,0,0);
    row("pr_0", 1,0,0,4'b1000,4'b0000, 4'b1000,0,0,0);
    row("pr_1b", 1,0,0,4'b1000,4'b1000, 4'b1000,0,0,0);
    row("pr_1c", 1,0,0,4'b1000,4'b1000, 4'b1000,0,0,0);
    row("pr_1d", 1,0,0,4'b1000,4'b1000, 4'b1000,0,0,0);
    row("pr_hit", 1,0,0,4'b0000,4'b0000, 4'b0000,1,3,0);

`ifdef SEQ_DET_SCHED_CNT_EN
    drive(1, 1, 4'b1111, 4'b0000, 4'b0000);
    tick();
    drive(1, 0, 4'b0000, 4'b0000, 4'b0000);
    repeat (4) tick();
    drive(1, 0, 4'b0000, 4'b1000, 4'b1000);
    repeat (303) tick();
    drive(1, 0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    cnt_sel = 2'd3;
    #1;
    n_vec++;
    if (cnt_data !== 8'd255) begin
      n_bad++;
      $display("FAIL cnt_sat: got %0d want 255", cnt_data);
    end
    drive(1, 1, 4'b0111, 4'b0000, 4'b0000);
    tick();
    drive(1, 0, 4'b0000, 4'b0000, 4'b0000);
    repeat (4) tick();
    n_vec++;
    if (cnt_data !== 8'd0) begin
      n_bad++;
      $display("FAIL cnt_clr: got %0d want 0", cnt_data);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
